// File: rtl/dispatch_queue_if.sv
// Dispatch packet type and the rename/RS-facing bus bundle of the dispatch queue.
package dispatch_queue_pkg;
  localparam int unsigned MACHINE_WIDTH = 4;

  typedef struct packed {
    logic        packet_valid;
    logic [6:0]  rob_tag;
    logic [23:0] payload;
  } dispatch_rs_packet_t;
endpackage

interface dispatch_queue_if #(
  parameter int unsigned QDEPTH = 16
);
  import dispatch_queue_pkg::*;

  localparam int unsigned MW    = MACHINE_WIDTH;
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  dispatch_rs_packet_t [MW-1:0] in_pkt;
  logic [MW-1:0]                in_ready;
  dispatch_rs_packet_t [MW-1:0] out_pkt;
  logic [MW-1:0]                rs_ready;
  logic [CNT_W-1:0]             q_count;
  logic                         q_empty;
  logic                         q_full;

  modport slave (
    input  in_pkt, rs_ready,
    output in_ready, out_pkt, q_count, q_empty, q_full
  );

  modport master (
    output in_pkt, rs_ready,
    input  in_ready, out_pkt, q_count, q_empty, q_full
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order circular buffer between rename and the RS bank; up to MACHINE_WIDTH
// packets in and out per cycle, outputs driven only from stored state.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned QDEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pipe_flush,
  dispatch_queue_if.slave dq
);

  localparam int unsigned MW = MACHINE_WIDTH;
  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MW) + 1;

  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [PW-1:0]       count;
  dispatch_rs_packet_t mem_q [QDEPTH];

  logic [MW-1:0]                in_rdy;
  logic [MW-1:0]                wr_en;
  logic [MW-1:0]                out_valid;
  dispatch_rs_packet_t [MW-1:0] out_pkt_c;
  logic [CW-1:0]                enq_cnt;
  logic [CW-1:0]                deq_cnt;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign count       = tail_q - head_q;
  assign dq.q_count  = count;
  assign dq.q_empty  = (count == '0);
  assign dq.q_full   = (count == PW'(QDEPTH));
  assign dq.in_ready = in_rdy;
  assign dq.out_pkt  = out_pkt_c;

  // Credit comes from start-of-cycle occupancy only.
  always_comb begin
    in_rdy = '0;
    for (int i = 0; i < int'(MW); i++) begin
      in_rdy[i] = !rst && !pipe_flush && ((32'(count) + 32'(i)) < 32'(QDEPTH));
    end
  end

  always_comb begin
    out_pkt_c = '0;
    out_valid = '0;
    for (int i = 0; i < int'(MW); i++) begin
      out_pkt_c[i] = mem_q[head_q[AW-1:0] + AW'(i)];
      out_valid[i] = out_pkt_c[i].packet_valid && (32'(i) < 32'(count));
      out_pkt_c[i].packet_valid = out_valid[i];
    end
  end

  // Only the contiguous run from lane 0 moves on either side.
  always_comb begin
    logic acc_run;
    logic deq_run;
    wr_en   = '0;
    enq_cnt = '0;
    deq_cnt = '0;
    acc_run = 1'b1;
    deq_run = !pipe_flush;
    for (int i = 0; i < int'(MW); i++) begin
      acc_run  = acc_run & dq.in_pkt[i].packet_valid & in_rdy[i];
      deq_run  = deq_run & out_valid[i] & dq.rs_ready[i];
      wr_en[i] = acc_run;
      enq_cnt  = enq_cnt + CW'(acc_run);
      deq_cnt  = deq_cnt + CW'(deq_run);
    end
  end

  always_comb begin
    head_d = head_q + PW'(deq_cnt);
    tail_d = tail_q + PW'(enq_cnt);
    if (pipe_flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int j = 0; j < int'(QDEPTH); j++) begin
        mem_q[j].packet_valid <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (pipe_flush) begin
        for (int j = 0; j < int'(QDEPTH); j++) begin
          mem_q[j].packet_valid <= 1'b0;
        end
      end
      for (int i = 0; i < int'(MW); i++) begin
        if (wr_en[i]) begin
          mem_q[tail_q[AW-1:0] + AW'(i)] <= dq.in_pkt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(count) <= 32'(QDEPTH));
      assert ((wr_en & ~in_rdy) == '0);
      assert ((out_valid & (out_valid + MW'(1))) == '0);
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: directed scenarios followed by random traffic.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int unsigned QDEPTH = 16;
  localparam int unsigned MW     = MACHINE_WIDTH;

  logic clk;
  logic rst;
  logic pipe_flush;

  dispatch_queue_if #(.QDEPTH(QDEPTH)) dq ();

  dispatch_queue #(.QDEPTH(QDEPTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_flush (pipe_flush),
    .dq         (dq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packets in arrival order; front is the oldest.
  dispatch_rs_packet_t exp_q[$];
  int unsigned checks;
  int unsigned passes;
  int unsigned seq;
  bit          mon_en;
  bit          cyc_rst;
  bit          cyc_flush;
  int unsigned occ_start;
  logic [MW-1:0] exp_ready;

  function automatic int unsigned lead_ones(input logic [MW-1:0] v);
    int unsigned n;
    bit run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < int'(MW); i++) begin
      run = run & v[i];
      if (run) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus; accepted packets are pushed as expected output.
  task automatic step(input bit r, input bit f, input int unsigned nvalid,
                      input logic [MW-1:0] rs);
    dispatch_rs_packet_t p;
    int unsigned room;
    @(posedge clk);
    #1;
    rst         = r;
    pipe_flush  = f;
    dq.rs_ready = rs;
    occ_start   = exp_q.size();
    room        = (r || f) ? 0 : QDEPTH - occ_start;
    for (int unsigned i = 0; i < MW; i++) begin
      exp_ready[i]   = (room > i);
      p.packet_valid = (i < nvalid);
      p.rob_tag      = 7'($urandom);
      p.payload      = 24'(seq);
      if (p.packet_valid) seq++;
      dq.in_pkt[i] = p;
      if (p.packet_valid && (i < room)) exp_q.push_back(p);
    end
    cyc_rst   = r;
    cyc_flush = f;
    mon_en    = 1'b1;
  endtask

  // Monitor: compare presented lanes, then retire the transferred prefix.
  always @(negedge clk) begin
    int unsigned n;
    if (mon_en) begin
      chk("in_ready", 64'(dq.in_ready), 64'(exp_ready));
      if (!cyc_rst) begin
        chk("q_count", 64'(dq.q_count), 64'(occ_start));
        chk("q_empty", 64'(dq.q_empty), 64'(occ_start == 0));
        chk("q_full",  64'(dq.q_full),  64'(occ_start == QDEPTH));
        for (int unsigned i = 0; i < MW; i++) begin
          if (i < occ_start)
            chk($sformatf("out_lane%0d", i), 64'(dq.out_pkt[i]), 64'(exp_q[i]));
          else
            chk($sformatf("out_valid%0d", i), 64'(dq.out_pkt[i].packet_valid), 64'(0));
        end
      end
      if (cyc_rst || cyc_flush) begin
        exp_q.delete();
      end else begin
        n = lead_ones(dq.rs_ready);
        if (n > occ_start) n = occ_start;
        repeat (n) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    rst         = 1'b1;
    pipe_flush  = 1'b0;
    dq.in_pkt   = '0;
    dq.rs_ready = '0;
    checks      = 0;
    passes      = 0;
    seq         = 0;
    mon_en      = 1'b0;
    cyc_rst     = 1'b1;
    cyc_flush   = 1'b0;
    occ_start   = 0;
    exp_ready   = '0;

    // Reset with random input traffic.
    repeat (2) step(1'b1, 1'b0, $urandom_range(0, MW), MW'($urandom));
    // Fill to full, then a rejected fifth burst.
    repeat (5) step(1'b0, 1'b0, 4, '0);
    // Partial drain, two per cycle.
    repeat (2) step(1'b0, 1'b0, 0, 4'b0011);
    // Refill, then enqueue and dequeue together at full.
    step(1'b0, 1'b0, 4, '0);
    step(1'b0, 1'b0, 4, 4'b1111);
    step(1'b0, 1'b0, 4, '0);
    // Steady streaming across pointer wrap.
    repeat (20) step(1'b0, 1'b0, 3, 4'b1111);
    // Build occupancy 9, flush with traffic, then a fresh packet leads.
    step(1'b0, 1'b1, 0, '0);
    step(1'b0, 1'b0, 4, '0);
    step(1'b0, 1'b0, 4, '0);
    step(1'b0, 1'b0, 1, '0);
    step(1'b0, 1'b1, 4, 4'b0011);
    step(1'b0, 1'b0, 1, '0);
    step(1'b0, 1'b0, 0, 4'b1111);
    // Random traffic, including non-thermometer rs_ready, flushes and resets.
    repeat (400) begin
      r = $urandom_range(0, 99);
      step(r == 0, (r >= 1) && (r <= 4), $urandom_range(0, MW),
           ($urandom_range(0, 2) == 0) ? MW'(0) : MW'($urandom));
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
